// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data path.
// Latency: grants are combinational, the access is on mem_* one cycle later, and read data returns RD_LAT+2 cycles after the grant.
// Backpressure: requests stall until granted; there is none on returns, so the port sustains one access per cycle.
//
// Ports:
//   i_clk, i_rst                          clock, synchronous active-high reset
//   i_if_req/i_if_addr/i_if_flush         fetch request, word address, redirect flush
//   o_if_gnt/o_if_rvalid/o_if_rdata       fetch grant, read return pulse, read data (held)
//   i_d_req/i_d_we/i_d_addr/i_d_wdata     data request, store flag, byte address, store data
//   o_d_gnt/o_d_rvalid/o_d_rdata          data grant, load return pulse, load data (held)
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_rdata   memory macro port
module mem_port_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [18:0]       i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [31:0]       o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [31:0]       i_d_addr,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [31:0]       o_d_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0]     r_starve_cnt;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    // Read tags: stage 0 holds the access currently on mem_*, stage RD_LAT
    // is the cycle in which its data is on i_mem_rdata.
    logic [RD_LAT:0]   r_tag_vld;
    logic [RD_LAT:0]   r_tag_fetch;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [31:0]       r_if_rdata;
    logic [31:0]       r_d_rdata;

    logic              w_starved;
    logic              w_if_gnt;
    logic              w_d_gnt;
    logic [RD_LAT:0]   w_tag_live;
    logic              w_unused;

    assign w_starved = (r_starve_cnt == SW'(STARVE_MAX));

    // Data normally wins; a fetch that has waited STARVE_MAX cycles takes the
    // port. A redirect blocks fetch, so data may still win in a starved cycle.
    assign w_if_gnt = !i_rst && i_if_req && !i_if_flush && (!i_d_req || w_starved);
    assign w_d_gnt  = !i_rst && i_d_req && !w_if_gnt;

    // A redirect kills every fetch tag in the pipe this cycle, including the
    // one leaving it, so its data is never returned.
    assign w_tag_live = r_tag_vld & ~(r_tag_fetch & {(RD_LAT + 1){i_if_flush}});

    // Byte offset and the upper address bits deliberately wrap.
    assign w_unused = ^{i_if_addr[18:ADDR_W], i_d_addr[31:ADDR_W+2], i_d_addr[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_tag_vld    <= '0;
            r_tag_fetch  <= '0;
            r_if_rvalid  <= 1'b0;
            r_d_rvalid   <= 1'b0;
            r_if_rdata   <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_mem_en    <= w_if_gnt || w_d_gnt;
            r_mem_we    <= w_d_gnt && i_d_we;
            r_mem_wdata <= (w_d_gnt && i_d_we) ? i_d_wdata : '0;
            if (w_if_gnt) begin
                r_mem_addr <= i_if_addr[ADDR_W-1:0];
            end else if (w_d_gnt) begin
                r_mem_addr <= i_d_addr[ADDR_W+1:2];
            end else begin
                r_mem_addr <= '0;
            end

            // Only reads are tagged; stores never produce a return.
            r_tag_vld   <= {w_tag_live[RD_LAT-1:0], w_if_gnt || (w_d_gnt && !i_d_we)};
            r_tag_fetch <= {r_tag_fetch[RD_LAT-1:0], w_if_gnt};

            r_if_rvalid <= w_tag_live[RD_LAT] && r_tag_fetch[RD_LAT];
            r_d_rvalid  <= w_tag_live[RD_LAT] && !r_tag_fetch[RD_LAT];
            if (w_tag_live[RD_LAT] && r_tag_fetch[RD_LAT]) begin
                r_if_rdata <= i_mem_rdata;
            end
            if (w_tag_live[RD_LAT] && !r_tag_fetch[RD_LAT]) begin
                r_d_rdata <= i_mem_rdata;
            end

            if (i_if_req && !w_if_gnt) begin
                if (!w_starved) begin
                    r_starve_cnt <= r_starve_cnt + SW'(1);
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

    assign o_if_gnt    = w_if_gnt;
    assign o_d_gnt     = w_d_gnt;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_rvalid = r_if_rvalid;
    assign o_d_rvalid  = r_d_rvalid;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations plus
// a transaction-level model (pending-read list keyed by return cycle) checked every cycle.
// The bench acts as the memory macro, supplying a known data word for every cycle.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 17;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, d_req, d_we;
    logic [18:0] if_addr;
    logic [31:0] d_addr, d_wdata, mem_rdata;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_on = 1'b0;
    logic [31:0] ovr [int];

    mem_port_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] data_for(input int c);
        if (ovr.exists(c)) return ovr[c];
        return (32'(c) * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    // Memory macro: the word presented during cycle c is data_for(c).
    always @(posedge clk) begin
        #1;
        mem_rdata = data_for(cyc);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct { int rv; bit f; } rd_t;
    rd_t pq[$];
    rd_t nq[$];
    int  m_starve = 0;
    bit  m_en = 0, m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_d_rdata = 0;

    always @(negedge clk) begin : model
        bit e_if, e_d, e_ifv, e_dv;
        if (chk_on) begin
            e_if = !rst && if_req && !if_flush && (!d_req || m_starve == STARVE_MAX);
            e_d  = !rst && d_req && !e_if;
            chk("m_if_gnt", if_gnt, e_if);
            chk("m_d_gnt", d_gnt, e_d);
            chk("m_mem_en", mem_en, m_en);
            chk("m_mem_we", mem_we, m_we);
            if (m_en) chk("m_mem_addr", 32'(mem_addr), m_addr);
            if (m_en && m_we) chk("m_mem_wdata", mem_wdata, m_wdata);
            e_ifv = 0;
            e_dv  = 0;
            foreach (pq[i]) begin
                if (pq[i].rv == cyc) begin
                    // Data was on the memory port the cycle before the return.
                    if (pq[i].f) begin e_ifv = 1; m_if_rdata = data_for(cyc - 1); end
                    else         begin e_dv  = 1; m_d_rdata  = data_for(cyc - 1); end
                end
            end
            chk("m_if_rvalid", if_rvalid, e_ifv);
            chk("m_d_rvalid", d_rvalid, e_dv);
            chk("m_if_rdata", if_rdata, m_if_rdata);
            chk("m_d_rdata", d_rdata, m_d_rdata);

            nq.delete();
            if (rst) begin
                m_starve = 0; m_en = 0; m_we = 0; m_if_rdata = 0; m_d_rdata = 0;
            end else begin
                // Undelivered fetch reads are cancelled by a redirect.
                foreach (pq[i])
                    if (pq[i].rv > cyc && !(if_flush && pq[i].f)) nq.push_back(pq[i]);
                m_en    = e_if || e_d;
                m_we    = e_d && d_we;
                m_addr  = e_if ? 32'(if_addr[16:0]) : 32'(d_addr[18:2]);
                m_wdata = d_wdata;
                if (e_if || (e_d && !d_we)) nq.push_back('{rv: cyc + RD_LAT + 2, f: e_if});
                if (if_req && !e_if) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
                else                 m_starve = 0;
            end
            pq = nq;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic ir, input logic [18:0] ia, input logic fl,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
        if_req = ir; if_addr = ia; if_flush = fl;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    endtask
    task automatic idle(); drv(0, 19'h0, 0, 0, 0, 32'h0, 32'h0); endtask
    task automatic step(); @(posedge clk); #1; endtask
    task automatic settle(); #2; endtask

    int t;
    bit ih, dh;
    initial begin
        rst = 1'b1;
        mem_rdata = 32'h0;
        drv(1, 19'h1, 0, 1, 0, 32'h4, 32'h0);
        step(); step();
        chk_on = 1'b1;
        settle();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_if_rdata", if_rdata, 0);
        step();
        rst = 1'b0;
        idle();
        step();

        // 1: single fetch
        t = cyc; ovr[t + 3] = 32'hDEADBEEF;
        drv(1, 19'h10, 0, 0, 0, 32'h0, 32'h0); settle(); chk("t1_if_gnt", if_gnt, 1); step();
        idle(); settle();
        chk("t1_mem_en", mem_en, 1); chk("t1_mem_addr", 32'(mem_addr), 32'h10); chk("t1_mem_we", mem_we, 0);
        step(); step(); step();
        settle(); chk("t1_if_rvalid", if_rvalid, 1); chk("t1_if_rdata", if_rdata, 32'hDEADBEEF); step();
        settle(); chk("t1_rvalid_pulse", if_rvalid, 0); chk("t1_rdata_hold", if_rdata, 32'hDEADBEEF); step();

        // 2: simultaneous fetch and load, data wins
        t = cyc; ovr[t + 3] = 32'hCAFE0001; ovr[t + 4] = 32'hCAFE0002;
        drv(1, 19'h33, 0, 1, 0, 32'h200, 32'h0); settle();
        chk("t2_d_gnt", d_gnt, 1); chk("t2_if_gnt0", if_gnt, 0); step();
        drv(1, 19'h33, 0, 0, 0, 32'h0, 32'h0); settle();
        chk("t2_if_gnt1", if_gnt, 1); chk("t2_mem_addr_d", 32'(mem_addr), 32'h80); step();
        idle(); settle(); chk("t2_mem_addr_if", 32'(mem_addr), 32'h33); step();
        step();
        settle(); chk("t2_d_rvalid", d_rvalid, 1); chk("t2_d_rdata", d_rdata, 32'hCAFE0001);
        chk("t2_if_rvalid_early", if_rvalid, 0); step();
        settle(); chk("t2_if_rvalid", if_rvalid, 1); chk("t2_if_rdata", if_rdata, 32'hCAFE0002); step();

        // 3: starvation forces fetch through on the fifth cycle
        for (int k = 0; k < 10; k++) begin
            drv(k <= 4, 19'h1AB, 0, 1, 0, 32'h1000 + 32'(4 * (k < 4 ? k : k - 1)), 32'h0);
            settle();
            chk("t3_if_gnt", if_gnt, k == 4);
            chk("t3_d_gnt", d_gnt, k != 4);
            step();
        end
        idle(); repeat (5) step();

        // 3b: redirect in the starved cycle gives the slot to data; fetch wins next
        for (int k = 0; k < 7; k++) begin
            drv(k <= 5, 19'h2CD, k == 4, 1, 1, 32'h2000 + 32'(4 * k), 32'(k));
            settle();
            chk("t3b_if_gnt", if_gnt, k == 5);
            chk("t3b_d_gnt", d_gnt, k != 5);
            step();
        end
        idle(); repeat (5) step();

        // 4: store
        drv(0, 19'h0, 0, 1, 1, 32'h107, 32'h5); settle(); chk("t4_d_gnt", d_gnt, 1); step();
        idle(); settle();
        chk("t4_mem_en", mem_en, 1); chk("t4_mem_we", mem_we, 1);
        chk("t4_mem_addr", 32'(mem_addr), 32'h41); chk("t4_mem_wdata", mem_wdata, 32'h5); step();
        for (int k = 0; k < 5; k++) begin settle(); chk("t4_no_d_rvalid", d_rvalid, 0); step(); end

        // 5: redirect kills a fetch in flight, load still returns
        t = cyc; ovr[t + 4] = 32'h600D0005;
        drv(1, 19'h55, 0, 0, 0, 32'h0, 32'h0); settle(); chk("t5_if_gnt", if_gnt, 1); step();
        drv(0, 19'h0, 0, 1, 0, 32'h40, 32'h0); settle(); chk("t5_d_gnt", d_gnt, 1); step();
        drv(0, 19'h0, 1, 0, 0, 32'h0, 32'h0); step();
        idle();
        for (int k = 3; k <= 6; k++) begin
            settle();
            chk("t5_no_if_rvalid", if_rvalid, 0);
            chk("t5_d_rvalid", d_rvalid, k == 5);
            if (k == 5) chk("t5_d_rdata", d_rdata, 32'h600D0005);
            step();
        end

        // 5b: redirect while the fetch tag is in its last stage
        drv(1, 19'h66, 0, 0, 0, 32'h0, 32'h0); step();
        idle(); step(); step();
        drv(0, 19'h0, 1, 0, 0, 32'h0, 32'h0); step();
        idle();
        for (int k = 0; k < 3; k++) begin settle(); chk("t5b_no_if_rvalid", if_rvalid, 0); step(); end

        // 6: reset with two loads in flight
        drv(0, 19'h0, 0, 1, 0, 32'h100, 32'h0); settle(); chk("t6_d_gnt", d_gnt, 1); step();
        drv(0, 19'h0, 0, 1, 0, 32'h104, 32'h0); step();
        rst = 1'b1; drv(1, 19'h7, 0, 1, 0, 32'h108, 32'h0); settle();
        chk("t6_rst_if_gnt", if_gnt, 0); chk("t6_rst_d_gnt", d_gnt, 0); step();
        rst = 1'b0; idle();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("t6_d_rvalid", d_rvalid, 0); chk("t6_d_rdata", d_rdata, 0);
            chk("t6_if_rdata", if_rdata, 0); chk("t6_mem_en", mem_en, 0);
            step();
        end

        // 7: address wrap on both requesters
        drv(0, 19'h0, 0, 1, 1, 32'hFFFFFFFE, 32'h1234); step();
        drv(1, 19'h7FFFF, 0, 0, 0, 32'h0, 32'h0); settle();
        chk("t7_d_wrap", 32'(mem_addr), 32'h1FFFF); step();
        idle(); settle(); chk("t7_if_wrap", 32'(mem_addr), 32'h1FFFF); step();
        repeat (5) step();

        // Random traffic with held requests, checked by the model
        ih = 0; dh = 0;
        for (int k = 0; k < 300; k++) begin
            if (!ih) begin if_req = ($urandom_range(0, 2) != 0); if_addr = 19'($urandom); end
            if (!dh) begin
                d_req = ($urandom_range(0, 2) != 0); d_we = $urandom_range(0, 1) == 1;
                d_addr = $urandom; d_wdata = $urandom;
            end
            if_flush = ($urandom_range(0, 9) == 0);
            rst = (k == 150);
            settle();
            ih = if_req && !if_gnt;
            dh = d_req && !d_gnt;
            step();
        end
        rst = 1'b0; idle();
        repeat (RD_LAT + 4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
